pipelined_addsub: RTL

- Parametrised, pipelined ripple-carry adder/subtractor. It is the next generation of the team's 4-bit full-adder chain.
- The WIDTH-bit operation is split into STAGES chunk slices. Each slice is registered and the carry passes between stages, so throughput is one operation per clock at wide widths.
- Operands and results move through a valid/ready handshake with back-pressure.
- Status flags are produced alongside each result. The block sits between the operand register file and the datapath result bus.

---
 rtl/addsub_pkg.sv | 11 +
 rtl/addsub_slice.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_addsub.sv | 135 +++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants and helpers for the pipelined adder/subtractor
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - W-bit combinational ripple adder built from full_adder cells
module addsub_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[W];
  // Carry into the MSB; the top XORs it with cout for signed overflow.
  assign c_msb = c[W-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - STAGES-deep pipelined ripple adder/subtractor with valid/ready flow
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic stall;
  logic accept;

  // Stage inputs: stage 0 sees the port operands, stage k sees stage k-1's registers.
  logic [WIDTH-1:0] x_in [STAGES];
  logic [WIDTH-1:0] y_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [CHUNK-1:0] sl_sum  [STAGES];
  logic             sl_cout [STAGES];
  logic             sl_cmsb [STAGES];

  logic [WIDTH-1:0] x_d [STAGES];
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] y_d [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_d [STAGES];
  logic             c_q [STAGES];
  logic             v_d [STAGES];
  logic             v_q [STAGES];
  logic             ovf_d;
  logic             ovf_q;
  logic             zero_d;
  logic             zero_q;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  always_comb begin : stage_inputs
    // Bubbles enter with zeroed data so idle stages never carry stale operands.
    x_in[0] = accept ? X : '0;
    y_in[0] = accept ? ((Sub == OP_ADD) ? Y : ~Y) : '0;
    c_in[0] = accept & (Cin ^ (Sub == OP_SUB));
    s_in[0] = '0;
    v_in[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      x_in[k] = x_q[k-1];
      y_in[k] = y_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(
      .W (CHUNK)
    ) u_slice (
      .a     (x_in[k][k*CHUNK +: CHUNK]),
      .b     (y_in[k][k*CHUNK +: CHUNK]),
      .cin   (c_in[k]),
      .sum   (sl_sum[k]),
      .cout  (sl_cout[k]),
      .c_msb (sl_cmsb[k])
    );
  end

  always_comb begin : stage_next
    for (int k = 0; k < STAGES; k++) begin
      x_d[k] = x_in[k];
      y_d[k] = y_in[k];
      c_d[k] = sl_cout[k];
      v_d[k] = v_in[k];
      s_d[k] = s_in[k];
      s_d[k][k*CHUNK +: CHUNK] = sl_sum[k];
    end
    ovf_d  = v_in[STAGES-1] & (sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1]);
    zero_d = v_in[STAGES-1] & (s_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule
